// File: rtl/ahb_slave_if.sv
// ahb_slave_if -- AHB-Lite slave front end for the APB bridge.
//
// Qualifies each AHB address phase, decodes it to one of three 64 MB slave
// regions, and holds the two-deep address/data pipeline that the bridge FSM
// consumes. Illegal transfers are caught before they reach the bridge:
// unmapped address, bad size, misalignment, or a SEQ beat that breaks the
// open burst. This block drives the two-cycle AHB ERROR response for them.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   Hwrite          write indicator (address phase)
//   Hreadyin        bus HREADY; the address/data phase advances when 1
//   Htrans          transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   Hsize, Hburst   transfer size and burst type
//   Haddr, Hwdata   address (address phase), write data (data phase)
//   valid           legal active transfer in the current address phase
//   tempselx        one-hot region decode of Haddr, 0 if unmapped
//   Haddr1/Haddr2   address one/two accepted phases old
//   Hwdata1/Hwdata2 write data one/two stages old
//   Hwritereg       Hwrite of the previous accepted phase
//   Hresp           00 OKAY, 01 ERROR
//   err_hready      ANDed with the bridge Hreadyout; low in the first error cycle
module ahb_slave_if #(
    parameter logic [31:0] BASE0       = 32'h8000_0000,
    parameter logic [31:0] BASE1       = 32'h8400_0000,
    parameter logic [31:0] BASE2       = 32'h8800_0000,
    parameter int          REGION_BITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hsize,
    input  logic [2:0]  Hburst,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic        valid,
    output logic [2:0]  tempselx,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [1:0]  Hresp,
    output logic        err_hready
);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef enum logic [1:0] {E_IDLE, E_ERR1, E_ERR2} err_state_t;

    err_state_t  state, state_nxt;

    // Burst tracker state
    logic        burst_open;
    logic        burst_fixed;
    logic [4:0]  beats_left;
    logic [31:0] exp_addr;
    logic [31:0] wrap_mask;
    logic [2:0]  burst_size;
    logic        burst_write;

    logic        act;
    logic        ill;
    logic        misalign;
    logic        seq_bad;
    logic [31:0] inc;
    logic [4:0]  burst_beats;
    logic        open_wrap;
    logic [31:0] open_mask;
    logic [31:0] step_mask;
    logic [31:0] next_addr;

    // Region decode compares only the bits above the region size.
    always_comb begin
        tempselx = 3'b000;
        if (Haddr[31:REGION_BITS] == BASE0[31:REGION_BITS])
            tempselx = 3'b001;
        else if (Haddr[31:REGION_BITS] == BASE1[31:REGION_BITS])
            tempselx = 3'b010;
        else if (Haddr[31:REGION_BITS] == BASE2[31:REGION_BITS])
            tempselx = 3'b100;
    end

    assign act      = Hreadyin & Htrans[1];
    assign inc      = 32'd1 << Hsize;
    assign misalign = (Haddr & (inc - 32'd1)) != 32'd0;

    assign seq_bad = (Htrans == T_SEQ) &
                     (~burst_open | (Haddr != exp_addr) |
                      (Hsize != burst_size) | (Hwrite != burst_write));

    assign ill   = act & ((tempselx == 3'b000) | (Hsize > 3'd2) | misalign | seq_bad);
    assign valid = act & ~ill & (state != E_ERR1);

    // Beat count of a fixed-length burst; 0 for SINGLE/INCR.
    always_comb begin
        case (Hburst[2:1])
            2'b01:   burst_beats = 5'd4;
            2'b10:   burst_beats = 5'd8;
            2'b11:   burst_beats = 5'd16;
            default: burst_beats = 5'd0;
        endcase
    end

    // Wrapping bursts wrap within beats*size bytes; a mask of all ones makes
    // the same next-address formula a plain increment.
    assign open_wrap = ~Hburst[0] & (Hburst[2:1] != 2'b00);
    assign open_mask = open_wrap ? (({27'd0, burst_beats} << Hsize) - 32'd1) : '1;
    assign step_mask = (Htrans == T_NONSEQ) ? open_mask : wrap_mask;
    assign next_addr = (Haddr & ~step_mask) | ((Haddr + inc) & step_mask);

    // Address/data pipeline for the bridge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            // NOTE: non-blocking assignments let every stage sample the
            // pre-edge value of the one before, so Haddr2 gets the old Haddr1.
            Haddr2    <= Haddr1;
            Haddr1    <= Haddr;
            Hwdata2   <= Hwdata1;
            Hwdata1   <= Hwdata;
            Hwritereg <= Hwrite;
        end
    end

    // Burst tracker: frozen while the bus stalls and during the first error
    // cycle, when the bus phase is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_open  <= 1'b0;
            burst_fixed <= 1'b0;
            beats_left  <= '0;
            exp_addr    <= '0;
            wrap_mask   <= '0;
            burst_size  <= '0;
            burst_write <= 1'b0;
        end else if (Hreadyin && state != E_ERR1) begin
            if (ill) begin
                burst_open <= 1'b0;
            end else begin
                case (Htrans)
                    T_IDLE: burst_open <= 1'b0;
                    T_NONSEQ: begin
                        burst_open  <= (Hburst != 3'b000);
                        burst_fixed <= (Hburst[2:1] != 2'b00);
                        beats_left  <= (burst_beats == 5'd0) ? 5'd0 : burst_beats - 5'd1;
                        exp_addr    <= next_addr;
                        wrap_mask   <= open_mask;
                        burst_size  <= Hsize;
                        burst_write <= Hwrite;
                    end
                    T_SEQ: begin
                        // A legal SEQ always has its burst open here.
                        exp_addr <= next_addr;
                        if (burst_fixed) begin
                            beats_left <= beats_left - 5'd1;
                            if (beats_left == 5'd1)
                                burst_open <= 1'b0;
                        end
                    end
                    default: ;  // BUSY holds the tracker
                endcase
            end
        end
    end

    // Error FSM runs regardless of Hreadyin because it drives HREADY itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= E_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_nxt  = state;
        Hresp      = 2'b00;
        err_hready = 1'b1;
        case (state)
            E_IDLE: begin
                if (ill)
                    state_nxt = E_ERR1;
            end
            E_ERR1: begin
                Hresp      = 2'b01;
                err_hready = 1'b0;
                state_nxt  = E_ERR2;
            end
            E_ERR2: begin
                Hresp     = 2'b01;
                state_nxt = ill ? E_ERR1 : E_IDLE;
            end
            default: state_nxt = E_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed testbench for ahb_slave_if. Inputs change on the falling edge;
// combinational outputs are sampled 1 ns later, registered outputs 1 ns
// after the rising edge.
module tb_ahb_slave_if;

    logic        clk;
    logic        rst;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [1:0]  Hresp;
    logic        err_hready;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    ahb_slave_if dut (
        .clk        (clk),
        .rst        (rst),
        .Hwrite     (Hwrite),
        .Hreadyin   (Hreadyin),
        .Htrans     (Htrans),
        .Hsize      (Hsize),
        .Hburst     (Hburst),
        .Haddr      (Haddr),
        .Hwdata     (Hwdata),
        .valid      (valid),
        .tempselx   (tempselx),
        .Haddr1     (Haddr1),
        .Haddr2     (Haddr2),
        .Hwdata1    (Hwdata1),
        .Hwdata2    (Hwdata2),
        .Hwritereg  (Hwritereg),
        .Hresp      (Hresp),
        .err_hready (err_hready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one address phase on the falling edge, then settle 1 ns.
    task automatic drive(input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic [2:0] size,
                         input logic [2:0] burst, input logic [31:0] wdata);
        @(negedge clk);
        Htrans = trans;
        Haddr  = addr;
        Hwrite = wr;
        Hsize  = size;
        Hburst = burst;
        Hwdata = wdata;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-cycle ERROR response after the illegal phase has been clocked in.
    task automatic expect_error(input string tag);
        drive(IDLE, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
        check({tag, " err1 Hresp"}, 32'(Hresp), 32'h1);
        check({tag, " err1 err_hready"}, 32'(err_hready), 32'h0);
        tick();
        drive(IDLE, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
        check({tag, " err2 Hresp"}, 32'(Hresp), 32'h1);
        check({tag, " err2 err_hready"}, 32'(err_hready), 32'h1);
        tick();
        drive(IDLE, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
        check({tag, " idle Hresp"}, 32'(Hresp), 32'h0);
        check({tag, " idle err_hready"}, 32'(err_hready), 32'h1);
    endtask

    initial begin
        logic [31:0] incr4_addr [4];
        logic [31:0] wrap_addr  [4];
        incr4_addr = '{32'h8400_0000, 32'h8400_0004, 32'h8400_0008, 32'h8400_000C};
        wrap_addr  = '{32'h8800_0008, 32'h8800_000C, 32'h8800_0000, 32'h8800_0004};

        rst      = 1'b0;
        Hreadyin = 1'b1;
        Htrans   = IDLE;
        Hwrite   = 1'b0;
        Hsize    = 3'd2;
        Hburst   = 3'd0;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;

        // Reset state
        #2;
        check("rst Haddr1", Haddr1, 32'h0);
        check("rst Haddr2", Haddr2, 32'h0);
        check("rst Hwdata1", Hwdata1, 32'h0);
        check("rst Hwritereg", 32'(Hwritereg), 32'h0);
        check("rst Hresp", 32'(Hresp), 32'h0);
        check("rst err_hready", 32'(err_hready), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // Single write: address phase, then data phase
        drive(NONSEQ, 32'h8000_0010, 1'b1, 3'd2, 3'd0, 32'h0);
        check("single valid", 32'(valid), 32'h1);
        check("single tempselx", 32'(tempselx), 32'h1);
        tick();
        check("single Haddr1", Haddr1, 32'h8000_0010);
        check("single Hwritereg", 32'(Hwritereg), 32'h1);
        drive(IDLE, 32'h0, 1'b0, 3'd2, 3'd0, 32'hDEAD_BEEF);
        tick();
        check("single Hwdata1", Hwdata1, 32'hDEAD_BEEF);

        // INCR4 read burst
        for (int i = 0; i < 4; i++) begin
            drive(i == 0 ? NONSEQ : SEQ, incr4_addr[i], 1'b0, 3'd2, 3'b011, 32'h0);
            check($sformatf("incr4 valid b%0d", i), 32'(valid), 32'h1);
            check($sformatf("incr4 tempselx b%0d", i), 32'(tempselx), 32'h2);
            check($sformatf("incr4 Hresp b%0d", i), 32'(Hresp), 32'h0);
            tick();
        end
        // A fifth SEQ after the closed INCR4 is a burst violation
        drive(SEQ, 32'h8400_0010, 1'b0, 3'd2, 3'b011, 32'h0);
        check("incr4 overrun valid", 32'(valid), 32'h0);
        tick();
        expect_error("incr4 overrun");
        tick();

        // WRAP4 word burst wrapping at the 16-byte boundary
        for (int i = 0; i < 4; i++) begin
            drive(i == 0 ? NONSEQ : SEQ, wrap_addr[i], 1'b0, 3'd2, 3'b010, 32'h0);
            check($sformatf("wrap4 valid b%0d", i), 32'(valid), 32'h1);
            tick();
        end

        // WRAP4 with a non-wrapping third beat
        drive(NONSEQ, 32'h8800_0008, 1'b0, 3'd2, 3'b010, 32'h0);
        check("wrapbad b0 valid", 32'(valid), 32'h1);
        tick();
        drive(SEQ, 32'h8800_000C, 1'b0, 3'd2, 3'b010, 32'h0);
        check("wrapbad b1 valid", 32'(valid), 32'h1);
        tick();
        drive(SEQ, 32'h8800_0010, 1'b0, 3'd2, 3'b010, 32'h0);
        check("wrapbad b2 valid", 32'(valid), 32'h0);
        check("wrapbad b2 Hresp", 32'(Hresp), 32'h0);
        tick();
        expect_error("wrapbad");
        tick();

        // Unmapped address, then a legal NONSEQ during E_ERR2
        drive(NONSEQ, 32'h9000_0000, 1'b0, 3'd2, 3'd0, 32'h0);
        check("unmapped valid", 32'(valid), 32'h0);
        check("unmapped tempselx", 32'(tempselx), 32'h0);
        tick();
        drive(IDLE, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
        check("unmapped err1 Hresp", 32'(Hresp), 32'h1);
        check("unmapped err1 err_hready", 32'(err_hready), 32'h0);
        tick();
        drive(NONSEQ, 32'h8000_0000, 1'b0, 3'd2, 3'd0, 32'h0);
        check("err2 nonseq valid", 32'(valid), 32'h1);
        check("err2 nonseq Hresp", 32'(Hresp), 32'h1);
        check("err2 nonseq err_hready", 32'(err_hready), 32'h1);
        tick();
        drive(IDLE, 32'h0, 1'b0, 3'd2, 3'd0, 32'h0);
        check("after err2 Hresp", 32'(Hresp), 32'h0);
        check("after err2 err_hready", 32'(err_hready), 32'h1);
        tick();

        // Misaligned word, then oversize transfer
        drive(NONSEQ, 32'h8000_0002, 1'b0, 3'd2, 3'd0, 32'h0);
        check("misalign valid", 32'(valid), 32'h0);
        tick();
        expect_error("misalign");
        tick();
        drive(NONSEQ, 32'h8000_0000, 1'b0, 3'd3, 3'd0, 32'h0);
        check("size3 valid", 32'(valid), 32'h0);
        tick();
        expect_error("size3");
        tick();

        // INCR write burst with a 3-cycle stall
        drive(NONSEQ, 32'h8000_0100, 1'b1, 3'd2, 3'b001, 32'h1111_0000);
        check("incr b0 valid", 32'(valid), 32'h1);
        tick();
        drive(SEQ, 32'h8000_0104, 1'b1, 3'd2, 3'b001, 32'h2222_0000);
        check("incr b1 valid", 32'(valid), 32'h1);
        tick();
        check("incr Haddr1", Haddr1, 32'h8000_0104);
        check("incr Haddr2", Haddr2, 32'h8000_0100);
        check("incr Hwdata1", Hwdata1, 32'h2222_0000);
        check("incr Hwdata2", Hwdata2, 32'h1111_0000);
        Hreadyin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(SEQ, 32'h8000_0108, 1'b1, 3'd2, 3'b001, 32'h3333_0000 + 32'(i));
            check($sformatf("stall%0d valid", i), 32'(valid), 32'h0);
            tick();
        end
        check("stall Haddr1", Haddr1, 32'h8000_0104);
        check("stall Haddr2", Haddr2, 32'h8000_0100);
        check("stall Hwdata1", Hwdata1, 32'h2222_0000);
        check("stall Hwdata2", Hwdata2, 32'h1111_0000);
        @(negedge clk);
        Hreadyin = 1'b1;
        #1;
        check("resume valid", 32'(valid), 32'h1);
        tick();
        check("resume Haddr1", Haddr1, 32'h8000_0108);

        // Asynchronous reset mid-burst
        @(negedge clk);
        Htrans = IDLE;
        rst = 1'b0;
        #1;
        check("midrst Haddr1", Haddr1, 32'h0);
        check("midrst Haddr2", Haddr2, 32'h0);
        check("midrst Hwdata1", Hwdata1, 32'h0);
        check("midrst Hwdata2", Hwdata2, 32'h0);
        check("midrst Hwritereg", 32'(Hwritereg), 32'h0);
        check("midrst Hresp", 32'(Hresp), 32'h0);
        check("midrst err_hready", 32'(err_hready), 32'h1);
        #1;
        rst = 1'b1;
        drive(SEQ, 32'h8000_010C, 1'b1, 3'd2, 3'b001, 32'h0);
        check("postrst seq valid", 32'(valid), 32'h0);
        tick();
        expect_error("postrst seq");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
